// File: rtl/mem_bus_router.sv
// Registered 1-to-N router for the picorv32 native memory bus with access watchdog,
// decode-error responses and a sticky error-capture register driving an interrupt.
module mem_bus_router #(
    parameter int unsigned N_PORTS   = 8,
    parameter int unsigned SEL_MSB   = 30,
    parameter int unsigned SEL_LSB   = 27,
    parameter int unsigned TIMEOUT   = 1024,
    parameter logic [31:0] ERR_RDATA = 32'hDEADBEEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    s_mem_valid,
    output logic                    s_mem_ready,
    input  logic [31:0]             s_mem_addr,
    input  logic [31:0]             s_mem_wdata,
    input  logic [3:0]              s_mem_wstrb,
    output logic [31:0]             s_mem_rdata,
    output logic [N_PORTS-1:0]      m_mem_valid,
    input  logic [N_PORTS-1:0]      m_mem_ready,
    output logic [31:0]             m_mem_addr,
    output logic [31:0]             m_mem_wdata,
    output logic [3:0]              m_mem_wstrb,
    input  logic [32*N_PORTS-1:0]   m_mem_rdata,
    input  logic                    err_clr,
    output logic                    err_valid,
    output logic [1:0]              err_cause,
    output logic [31:0]             err_addr,
    output logic                    err_ovf,
    output logic                    err_irq
);

    localparam int unsigned IDX_W = SEL_MSB - SEL_LSB + 1;
    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

    state_e             r_state;
    logic [N_PORTS-1:0] r_m_valid;
    logic [31:0]        r_addr;
    logic [31:0]        r_wdata;
    logic [3:0]         r_wstrb;
    logic [CNT_W-1:0]   r_cnt;
    logic [31:0]        r_rdata;
    logic               r_s_ready;
    logic               r_err_valid;
    logic [1:0]         r_err_cause;
    logic [31:0]        r_err_addr;
    logic               r_err_ovf;

    logic [IDX_W-1:0]   w_idx;
    logic               w_dec_ok;
    logic [N_PORTS-1:0] w_onehot;
    logic               w_sel_ready;
    logic [31:0]        w_sel_rdata;
    logic               w_timeout;
    logic               w_start;
    logic               w_err_dec;
    logic               w_err_to;
    logic               w_err;

    assign w_idx       = s_mem_addr[SEL_MSB:SEL_LSB];
    assign w_dec_ok    = 32'(w_idx) < N_PORTS;
    // r_m_valid is one-hot on the selected port, so it masks out unselected ready/rdata
    assign w_sel_ready = |(m_mem_ready & r_m_valid);
    assign w_timeout   = (TIMEOUT != 0) && (r_cnt == CNT_LAST);
    // The response-pulse cycle is not an accept slot: the CPU is still holding its request
    assign w_start     = (r_state == StIdle) && s_mem_valid && !r_s_ready;
    assign w_err_dec   = w_start && !w_dec_ok;
    assign w_err_to    = (r_state == StAccess) && !w_sel_ready && w_timeout;
    assign w_err       = w_err_dec || w_err_to;

    always_comb begin
        w_onehot    = '0;
        w_sel_rdata = '0;
        for (int unsigned i = 0; i < N_PORTS; i++) begin
            w_onehot[i] = (32'(w_idx) == i);
            if (r_m_valid[i]) begin
                w_sel_rdata = w_sel_rdata | m_mem_rdata[32*i +: 32];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= StIdle;
            r_m_valid   <= '0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_wstrb     <= '0;
            r_cnt       <= '0;
            r_rdata     <= '0;
            r_s_ready   <= 1'b0;
            r_err_valid <= 1'b0;
            r_err_cause <= 2'b00;
            r_err_addr  <= '0;
            r_err_ovf   <= 1'b0;
        end else begin
            r_s_ready <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (w_start) begin
                        r_addr  <= s_mem_addr;
                        r_wdata <= s_mem_wdata;
                        r_wstrb <= s_mem_wstrb;
                        r_cnt   <= '0;
                        if (w_dec_ok) begin
                            r_m_valid <= w_onehot;
                            r_state   <= StAccess;
                        end else begin
                            r_rdata <= ERR_RDATA;
                            r_state <= StResp;
                        end
                    end
                end
                StAccess: begin
                    if (w_sel_ready) begin
                        r_rdata   <= w_sel_rdata;
                        r_m_valid <= '0;
                        r_state   <= StResp;
                    end else if (w_timeout) begin
                        r_rdata   <= ERR_RDATA;
                        r_m_valid <= '0;
                        r_state   <= StResp;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                StResp: begin
                    r_s_ready <= 1'b1;
                    r_state   <= StIdle;
                end
                default: r_state <= StIdle;
            endcase

            // A new error wins over a coincident clear and starts a fresh capture
            if (w_err && (err_clr || !r_err_valid)) begin
                r_err_valid <= 1'b1;
                r_err_cause <= w_err_dec ? 2'b01 : 2'b10;
                r_err_addr  <= r_addr;
                r_err_ovf   <= 1'b0;
                if (w_err_dec) begin
                    r_err_addr <= s_mem_addr;
                end
            end else if (w_err) begin
                r_err_ovf <= 1'b1;
            end else if (err_clr) begin
                r_err_valid <= 1'b0;
                r_err_cause <= 2'b00;
                r_err_addr  <= '0;
                r_err_ovf   <= 1'b0;
            end
        end
    end

    assign s_mem_ready = r_s_ready;
    assign s_mem_rdata = r_rdata;
    assign m_mem_valid = r_m_valid;
    assign m_mem_addr  = r_addr;
    assign m_mem_wdata = r_wdata;
    assign m_mem_wstrb = r_wstrb;
    assign err_valid   = r_err_valid;
    assign err_cause   = r_err_cause;
    assign err_addr    = r_err_addr;
    assign err_ovf     = r_err_ovf;
    assign err_irq     = r_err_valid;

endmodule

// File: tb/tb_mem_bus_router.sv
// Self-checking bench for mem_bus_router: directed scenarios plus randomized transactions
// checked against a latency/data/error model derived from the router's bus rules.
module tb_mem_bus_router;

    localparam int          NP   = 8;
    localparam int          TO   = 16;
    localparam logic [31:0] ERRD = 32'hDEADBEEF;
    localparam int          NEVER = 1000;

    logic              clk = 1'b0;
    logic              rst;
    logic              s_mem_valid;
    logic              s_mem_ready;
    logic [31:0]       s_mem_addr;
    logic [31:0]       s_mem_wdata;
    logic [3:0]        s_mem_wstrb;
    logic [31:0]       s_mem_rdata;
    logic [NP-1:0]     m_mem_valid;
    logic [NP-1:0]     m_mem_ready;
    logic [31:0]       m_mem_addr;
    logic [31:0]       m_mem_wdata;
    logic [3:0]        m_mem_wstrb;
    logic [32*NP-1:0]  m_mem_rdata;
    logic              err_clr;
    logic              err_valid;
    logic [1:0]        err_cause;
    logic [31:0]       err_addr;
    logic              err_ovf;
    logic              err_irq;

    mem_bus_router #(
        .N_PORTS  (NP),
        .SEL_MSB  (30),
        .SEL_LSB  (27),
        .TIMEOUT  (TO),
        .ERR_RDATA(ERRD)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .s_mem_valid(s_mem_valid),
        .s_mem_ready(s_mem_ready),
        .s_mem_addr (s_mem_addr),
        .s_mem_wdata(s_mem_wdata),
        .s_mem_wstrb(s_mem_wstrb),
        .s_mem_rdata(s_mem_rdata),
        .m_mem_valid(m_mem_valid),
        .m_mem_ready(m_mem_ready),
        .m_mem_addr (m_mem_addr),
        .m_mem_wdata(m_mem_wdata),
        .m_mem_wstrb(m_mem_wstrb),
        .m_mem_rdata(m_mem_rdata),
        .err_clr    (err_clr),
        .err_valid  (err_valid),
        .err_cause  (err_cause),
        .err_addr   (err_addr),
        .err_ovf    (err_ovf),
        .err_irq    (err_irq)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference error register
    logic        e_valid;
    logic [1:0]  e_cause;
    logic [31:0] e_addr;
    logic        e_ovf;

    // Transaction results
    int          lat;
    int          vlen;
    int          viol;
    logic [31:0] rd;

    function automatic int exp_lat(input int idx, input int w);
        if (idx >= NP) return 1;
        if (w >= TO) return TO + 1;
        return w + 2;
    endfunction

    function automatic int exp_vlen(input int idx, input int w);
        if (idx >= NP) return 0;
        if (w >= TO) return TO;
        return w + 1;
    endfunction

    function automatic logic [31:0] exp_rd(input int idx, input int w, input logic [31:0] sd);
        if (idx >= NP || w >= TO) return ERRD;
        return sd;
    endfunction

    task automatic model_clear();
        e_valid = 1'b0;
        e_cause = 2'b00;
        e_addr  = '0;
        e_ovf   = 1'b0;
    endtask

    task automatic model_txn(input int idx, input int w, input bit clr, input logic [31:0] addr);
        bit dec;
        bit tmo;
        dec = (idx >= NP);
        tmo = !dec && (w >= TO);
        if (clr && !dec) model_clear();
        if (dec || tmo) begin
            if ((clr && dec) || !e_valid) begin
                e_valid = 1'b1;
                e_cause = dec ? 2'b01 : 2'b10;
                e_addr  = addr;
                e_ovf   = 1'b0;
            end else begin
                e_ovf = 1'b1;
            end
        end
    endtask

    // CPU master plus a slave on the target port that answers after w wait cycles;
    // every other port drives random ready/rdata noise that must be ignored.
    task automatic run_txn(input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] wstrb, input int w, input logic [31:0] sd,
                           input bit clr);
        int tp;
        int k;
        tp   = int'((addr >> 27) & 32'hF);
        k    = 0;
        lat  = -1;
        vlen = 0;
        viol = 0;
        rd   = '0;
        s_mem_valid = 1'b1;
        s_mem_addr  = addr;
        s_mem_wdata = wdata;
        s_mem_wstrb = wstrb;
        err_clr     = clr;
        for (int n = 1; n <= 60; n++) begin
            @(posedge clk);
            #1;
            err_clr = 1'b0;
            if (|m_mem_valid) begin
                vlen++;
                if (tp >= NP || m_mem_valid !== (NP'(1) << tp) || m_mem_addr !== addr ||
                    m_mem_wdata !== wdata || m_mem_wstrb !== wstrb) viol++;
            end
            if (s_mem_ready) begin
                lat = n - 1;
                rd  = s_mem_rdata;
                break;
            end
            m_mem_ready = NP'($urandom);
            for (int i = 0; i < NP; i++) m_mem_rdata[32*i +: 32] = $urandom;
            if (tp < NP) begin
                m_mem_ready[tp] = 1'b0;
                if (m_mem_valid[tp]) begin
                    k++;
                    if (k >= w + 1) begin
                        m_mem_ready[tp]          = 1'b1;
                        m_mem_rdata[32*tp +: 32] = sd;
                    end
                end
            end
        end
        s_mem_valid = 1'b0;
        m_mem_ready = '0;
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        @(posedge clk);
        #1;
        err_clr = 1'b0;
        model_clear();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        model_clear();
        n_checks++;
        if ({s_mem_ready, s_mem_rdata, m_mem_valid, m_mem_addr, m_mem_wdata, m_mem_wstrb,
             err_valid, err_cause, err_addr, err_ovf, err_irq} !== '0)
            $display("FAIL reset_outputs: got rdy=%b rd=%h mv=%h ma=%h ev=%b ea=%h, need all 0",
                     s_mem_ready, s_mem_rdata, m_mem_valid, m_mem_addr, err_valid, err_addr);
        else n_pass++;
        rst = 1'b0;
    endtask

    task automatic test_read();
        run_txn(32'h2000_0010, 32'h0, 4'h0, 3, 32'h1234_5678, 1'b0);
        n_checks++;
        if (lat !== 5) $display("FAIL read_latency: got %0d need 5", lat);
        else n_pass++;
        n_checks++;
        if (rd !== 32'h1234_5678) $display("FAIL read_data: got %h need 12345678", rd);
        else n_pass++;
        n_checks++;
        if (viol !== 0 || vlen !== 4)
            $display("FAIL read_port4_valid: got viol=%0d len=%0d need 0/4", viol, vlen);
        else n_pass++;
        @(posedge clk);
        #1;
        n_checks++;
        if (s_mem_ready !== 1'b0) $display("FAIL read_single_pulse: got %b need 0", s_mem_ready);
        else n_pass++;
    endtask

    task automatic test_write();
        run_txn(32'h2800_0000, 32'hA5A5_A5A5, 4'hF, 2, 32'h0, 1'b0);
        n_checks++;
        if (viol !== 0 || vlen !== 3)
            $display("FAIL write_stable: got viol=%0d len=%0d need 0/3", viol, vlen);
        else n_pass++;
        n_checks++;
        if (lat !== 4) $display("FAIL write_latency: got %0d need 4", lat);
        else n_pass++;
        @(posedge clk);
        #1;
        n_checks++;
        if (s_mem_ready !== 1'b0) $display("FAIL write_single_pulse: got %b need 0", s_mem_ready);
        else n_pass++;
    endtask

    task automatic test_decode_error();
        run_txn(32'h4000_0000, 32'h0, 4'h0, 0, 32'h0, 1'b0);
        model_txn(8, 0, 1'b0, 32'h4000_0000);
        n_checks++;
        if (lat !== 1 || rd !== ERRD || vlen !== 0)
            $display("FAIL decode_resp: got lat=%0d rd=%h len=%0d need 1/%h/0", lat, rd, vlen, ERRD);
        else n_pass++;
        n_checks++;
        if ({err_valid, err_cause, err_addr, err_ovf, err_irq} !== {1'b1, 2'b01, 32'h4000_0000, 1'b0, 1'b1})
            $display("FAIL decode_err_reg: got v=%b c=%b a=%h o=%b irq=%b need 1/01/40000000/0/1",
                     err_valid, err_cause, err_addr, err_ovf, err_irq);
        else n_pass++;
        @(posedge clk);
        #1;
        pulse_clr();
    endtask

    task automatic test_timeout();
        run_txn(32'h0800_0004, 32'h1111_2222, 4'h3, NEVER, 32'h0, 1'b0);
        model_txn(1, NEVER, 1'b0, 32'h0800_0004);
        n_checks++;
        if (vlen !== TO || lat !== TO + 1 || rd !== ERRD)
            $display("FAIL timeout_resp: got len=%0d lat=%0d rd=%h need %0d/%0d/%h",
                     vlen, lat, rd, TO, TO + 1, ERRD);
        else n_pass++;
        n_checks++;
        if ({err_valid, err_cause, err_addr, err_ovf} !== {e_valid, e_cause, e_addr, e_ovf})
            $display("FAIL timeout_err_reg: got v=%b c=%b a=%h o=%b need %b/%b/%h/%b",
                     err_valid, err_cause, err_addr, err_ovf, e_valid, e_cause, e_addr, e_ovf);
        else n_pass++;
        @(posedge clk);
        #1;
        run_txn(32'h1800_0008, 32'h0, 4'h0, NEVER, 32'h0, 1'b0);
        model_txn(3, NEVER, 1'b0, 32'h1800_0008);
        n_checks++;
        if ({err_valid, err_cause, err_addr, err_ovf} !== {e_valid, e_cause, e_addr, e_ovf})
            $display("FAIL timeout_ovf: got v=%b c=%b a=%h o=%b need %b/%b/%h/%b",
                     err_valid, err_cause, err_addr, err_ovf, e_valid, e_cause, e_addr, e_ovf);
        else n_pass++;
        @(posedge clk);
        #1;
        pulse_clr();
        n_checks++;
        if ({err_valid, err_cause, err_addr, err_ovf, err_irq} !== '0)
            $display("FAIL err_clr: got v=%b c=%b a=%h o=%b irq=%b need all 0",
                     err_valid, err_cause, err_addr, err_ovf, err_irq);
        else n_pass++;
    endtask

    task automatic test_rst_mid();
        int pulses;
        s_mem_valid = 1'b1;
        s_mem_addr  = 32'h1000_0020;
        s_mem_wdata = 32'hCAFE_F00D;
        s_mem_wstrb = 4'hC;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        model_clear();
        n_checks++;
        if ({s_mem_ready, s_mem_rdata, m_mem_valid, m_mem_addr, m_mem_wdata, m_mem_wstrb,
             err_valid, err_cause, err_addr, err_ovf, err_irq} !== '0)
            $display("FAIL rst_mid_outputs: got mv=%h ma=%h rdy=%b need all 0",
                     m_mem_valid, m_mem_addr, s_mem_ready);
        else n_pass++;
        rst = 1'b0;
        s_mem_valid = 1'b0;
        pulses = 0;
        repeat (4) begin
            @(posedge clk);
            #1;
            if (s_mem_ready || |m_mem_valid) pulses++;
        end
        n_checks++;
        if (pulses !== 0) $display("FAIL rst_mid_quiet: got %0d active cycles need 0", pulses);
        else n_pass++;
        run_txn(32'h1800_0000, 32'h0, 4'h0, 1, 32'h0BAD_CAFE, 1'b0);
        n_checks++;
        if (lat !== 3 || rd !== 32'h0BAD_CAFE)
            $display("FAIL rst_mid_next_txn: got lat=%0d rd=%h need 3/0badcafe", lat, rd);
        else n_pass++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_clr_coincident();
        run_txn(32'h5000_0000, 32'h0, 4'h0, 0, 32'h0, 1'b0);
        model_txn(10, 0, 1'b0, 32'h5000_0000);
        @(posedge clk);
        #1;
        run_txn(32'h6000_0004, 32'h0, 4'h0, 0, 32'h0, 1'b0);
        model_txn(12, 0, 1'b0, 32'h6000_0004);
        @(posedge clk);
        #1;
        n_checks++;
        if (err_ovf !== 1'b1 || err_addr !== 32'h5000_0000)
            $display("FAIL ovf_keeps_first: got o=%b a=%h need 1/50000000", err_ovf, err_addr);
        else n_pass++;
        run_txn(32'h4800_000C, 32'h0, 4'h0, 0, 32'h0, 1'b1);
        model_txn(9, 0, 1'b1, 32'h4800_000C);
        n_checks++;
        if ({err_valid, err_cause, err_addr, err_ovf} !== {1'b1, 2'b01, 32'h4800_000C, 1'b0})
            $display("FAIL clr_coincident: got v=%b c=%b a=%h o=%b need 1/01/4800000c/0",
                     err_valid, err_cause, err_addr, err_ovf);
        else n_pass++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_random();
        int          idx;
        int          w;
        bit          clr;
        logic [31:0] addr;
        logic [31:0] sd;
        for (int t = 0; t < 24; t++) begin
            idx = ($urandom_range(0, 3) == 0) ? int'($urandom_range(8, 15))
                                              : int'($urandom_range(0, 7));
            w   = ($urandom_range(0, 2) == 0) ? int'($urandom_range(14, 17))
                                              : int'($urandom_range(0, 6));
            clr = ($urandom_range(0, 3) == 0);
            addr = $urandom;
            addr[30:27] = 4'(idx);
            sd = $urandom;
            run_txn(addr, $urandom, 4'($urandom), w, sd, clr);
            model_txn(idx, w, clr, addr);
            n_checks++;
            if (lat !== exp_lat(idx, w))
                $display("FAIL rnd%0d_latency: got %0d need %0d", t, lat, exp_lat(idx, w));
            else n_pass++;
            n_checks++;
            if (rd !== exp_rd(idx, w, sd))
                $display("FAIL rnd%0d_rdata: got %h need %h", t, rd, exp_rd(idx, w, sd));
            else n_pass++;
            n_checks++;
            if (viol !== 0 || vlen !== exp_vlen(idx, w))
                $display("FAIL rnd%0d_valid: got viol=%0d len=%0d need 0/%0d",
                         t, viol, vlen, exp_vlen(idx, w));
            else n_pass++;
            n_checks++;
            if ({err_valid, err_cause, err_addr, err_ovf, err_irq} !==
                {e_valid, e_cause, e_addr, e_ovf, e_valid})
                $display("FAIL rnd%0d_err_reg: got v=%b c=%b a=%h o=%b need %b/%b/%h/%b",
                         t, err_valid, err_cause, err_addr, err_ovf,
                         e_valid, e_cause, e_addr, e_ovf);
            else n_pass++;
            @(posedge clk);
            #1;
            n_checks++;
            if (s_mem_ready !== 1'b0) $display("FAIL rnd%0d_single_pulse: got 1 need 0", t);
            else n_pass++;
        end
    endtask

    initial begin
        rst         = 1'b1;
        s_mem_valid = 1'b0;
        s_mem_addr  = '0;
        s_mem_wdata = '0;
        s_mem_wstrb = '0;
        m_mem_ready = '0;
        m_mem_rdata = '0;
        err_clr     = 1'b0;
        model_clear();
        test_reset();
        test_read();
        test_write();
        test_decode_error();
        test_timeout();
        test_rst_mid();
        test_clr_coincident();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
